// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode-side and redirect signals.
// The master side is the fetch unit; the slave side is the memory/decode environment.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready;
    logic [INSTR_W-1:0] imem_resp_data;

    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;

    logic               redirect_valid;
    logic               redirect_mode;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               misalign;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_data,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        input  redirect_valid, redirect_mode, redirect_addr,
        output misalign
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_data,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        output redirect_valid, redirect_mode, redirect_addr,
        input  misalign
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, one-cycle-latency memory requests,
// an in-order prefetch buffer and absolute/relative redirects that flush everything.
module fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                INSTR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                PC_STEP      = 4,
    parameter int                DEPTH        = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [ADDR_W-1:0]  last_pc;
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               inflight;
    logic               misalign_q;

    logic               pop;
    logic               push;
    logic               accept;
    logic [CNT_W:0]     credit;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  raw_target;
    logic [ADDR_W-1:0]  target;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.out_valid = (count != '0);
    assign bus.out_instr = instr_q[rd_ptr];
    assign bus.out_pc    = pc_q[rd_ptr];
    assign bus.misalign  = misalign_q;

    // A redirect swallows both the pop and the pending response in its cycle.
    assign pop    = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
    assign push   = inflight & ~bus.redirect_valid;
    assign credit = {1'b0, count} - {{CNT_W{1'b0}}, pop} + {{CNT_W{1'b0}}, inflight};

    assign bus.imem_req_valid = ~bus.redirect_valid & (credit < (CNT_W + 1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign accept             = bus.imem_req_valid & bus.imem_req_ready;

    assign base       = bus.out_valid ? bus.out_pc : last_pc;
    assign raw_target = bus.redirect_mode ? (base + bus.redirect_addr) : bus.redirect_addr;
    assign target     = raw_target & ~LOW_MASK;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_resp_data;
            pc_q[wr_ptr]    <= inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_VECTOR;
            inflight_pc <= RESET_VECTOR;
            last_pc     <= RESET_VECTOR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= bus.redirect_valid & (|(raw_target & LOW_MASK));
            if (bus.redirect_valid) begin
                fetch_pc <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                inflight <= 1'b0;
            end else begin
                inflight <= accept;
                if (accept) begin
                    fetch_pc    <= fetch_pc + STEP;
                    inflight_pc <= fetch_pc;
                end
                if (push) begin
                    wr_ptr <= next_ptr(wr_ptr);
                end
                if (pop) begin
                    rd_ptr  <= next_ptr(rd_ptr);
                    last_pc <= bus.out_pc;
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a PC-sequence model checks every cycle,
// and literal expectations pin reset, latency, backpressure, redirects and wrap.
module tb_fetch_unit;
    localparam int          ADDR_W  = 32;
    localparam int          INSTR_W = 32;
    localparam int          DEPTH   = 2;
    localparam int          PC_STEP = 4;
    localparam logic [31:0] RV_A    = 32'h0000_0100;
    localparam logic [31:0] RV_B    = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_a ();
    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_b ();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_VECTOR(RV_A),
                 .PC_STEP(PC_STEP), .DEPTH(DEPTH)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_VECTOR(RV_B),
                 .PC_STEP(PC_STEP), .DEPTH(DEPTH)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC0DE_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic rm, input logic [31:0] raddr,
                                 input logic ordy, input logic qrdy);
        bus_a.redirect_valid = rv;
        bus_a.redirect_mode  = rm;
        bus_a.redirect_addr  = raddr;
        bus_a.out_ready      = ordy;
        bus_a.imem_req_ready = qrdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (bus_a.out_valid === 1'b1) found = 1'b1;
            else nextCycle();
        end
        checkOutput(name, {31'b0, found}, 32'd1);
    endtask

    // Memory returns instr_of(addr) in the cycle after acceptance, garbage otherwise.
    logic [31:0] pend_a = 32'hDEAD_BEEF;
    logic [31:0] pend_b = 32'hDEAD_BEEF;
    always @(negedge clk) begin
        pend_a = (bus_a.imem_req_valid && bus_a.imem_req_ready) ? instr_of(bus_a.imem_req_addr) : 32'hDEAD_BEEF;
        pend_b = (bus_b.imem_req_valid && bus_b.imem_req_ready) ? instr_of(bus_b.imem_req_addr) : 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        bus_a.imem_resp_data <= pend_a;
        bus_b.imem_resp_data <= pend_b;
    end

    // Model: next PC to deliver, next PC to request, and work outstanding since the last flush.
    logic [31:0] m_fetch_pc = RV_A;
    logic [31:0] m_next_pc  = RV_A;
    logic [31:0] m_last_pc  = RV_A;
    int          m_outstanding = 0;
    bit          m_prev_acc = 1'b0;
    bit          m_mis_pend = 1'b0;
    int          accepts_a = 0;
    logic [31:0] popped_a[$];
    logic [31:0] popped_b[$];

    always @(negedge clk) begin : compare
        bit          exp_out;
        bit          exp_req;
        bit          pop;
        bit          acc;
        logic [31:0] base;
        logic [31:0] raw;
        logic [31:0] tgt;
        if (reset) begin
            checkOutput("rst_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
            checkOutput("rst_misalign", {31'b0, bus_a.misalign}, 32'd0);
            checkOutput("rst_req_addr", bus_a.imem_req_addr, RV_A);
            m_fetch_pc    = RV_A;
            m_next_pc     = RV_A;
            m_last_pc     = RV_A;
            m_outstanding = 0;
            m_prev_acc    = 1'b0;
            m_mis_pend    = 1'b0;
        end else begin
            exp_out = (m_outstanding - int'(m_prev_acc)) > 0;
            pop     = exp_out && bus_a.out_ready && !bus_a.redirect_valid;
            exp_req = !bus_a.redirect_valid && ((m_outstanding - int'(pop)) < DEPTH);
            checkOutput("model_req_valid", {31'b0, bus_a.imem_req_valid}, {31'b0, exp_req});
            if (exp_req) checkOutput("model_req_addr", bus_a.imem_req_addr, m_fetch_pc);
            checkOutput("model_out_valid", {31'b0, bus_a.out_valid}, {31'b0, exp_out});
            if (exp_out) begin
                checkOutput("model_out_pc", bus_a.out_pc, m_next_pc);
                checkOutput("model_out_instr", bus_a.out_instr, instr_of(m_next_pc));
            end
            checkOutput("model_misalign", {31'b0, bus_a.misalign}, {31'b0, m_mis_pend});
            acc = exp_req && bus_a.imem_req_ready;
            if (acc) accepts_a++;
            if (pop) popped_a.push_back(bus_a.out_pc);
            if (bus_a.redirect_valid) begin
                base = exp_out ? m_next_pc : m_last_pc;
                raw  = bus_a.redirect_mode ? base + bus_a.redirect_addr : bus_a.redirect_addr;
                tgt  = raw & ~32'(PC_STEP - 1);
                m_mis_pend    = (raw & 32'(PC_STEP - 1)) != 0;
                m_fetch_pc    = tgt;
                m_next_pc     = tgt;
                m_outstanding = 0;
                m_prev_acc    = 1'b0;
            end else begin
                m_mis_pend = 1'b0;
                if (pop) begin
                    m_last_pc = m_next_pc;
                    m_next_pc = m_next_pc + PC_STEP;
                end
                if (acc) m_fetch_pc = m_fetch_pc + PC_STEP;
                m_outstanding = m_outstanding + int'(acc) - int'(pop);
                m_prev_acc    = acc;
            end
        end
        if (!reset && bus_b.out_valid && bus_b.out_ready) popped_b.push_back(bus_b.out_pc);
    end

    initial begin
        int snap;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_mode  = 1'b0;
        bus_b.redirect_addr  = 32'h0;
        bus_b.out_ready      = 1'b1;
        bus_b.imem_req_ready = 1'b1;

        // Reset state and first-fetch latency.
        repeat (2) nextCycle();
        @(negedge clk);
        checkOutput("reset_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        checkOutput("reset_req_addr", bus_a.imem_req_addr, 32'h100);
        nextCycle();
        reset = 1'b0;
        popped_a.delete();
        popped_b.delete();
        @(negedge clk);
        checkOutput("first_req_valid", {31'b0, bus_a.imem_req_valid}, 32'd1);
        checkOutput("first_req_addr", bus_a.imem_req_addr, 32'h100);
        nextCycle();
        @(negedge clk);
        checkOutput("c1_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("c2_out_valid", {31'b0, bus_a.out_valid}, 32'd1);
        checkOutput("c2_out_pc", bus_a.out_pc, 32'h100);
        repeat (6) nextCycle();
        checkOutput("freerun_pops", popped_a.size(), 32'd6);
        if (popped_a.size() >= 3)
            for (int i = 0; i < 3; i++) checkOutput("freerun_pc", popped_a[i], 32'h100 + 32'(4 * i));
        checkOutput("wrap_pops", popped_b.size(), 32'd6);
        if (popped_b.size() >= 3) begin
            checkOutput("wrap_pc0", popped_b[0], 32'hFFFF_FFF8);
            checkOutput("wrap_pc1", popped_b[1], 32'hFFFF_FFFC);
            checkOutput("wrap_pc2", popped_b[2], 32'h0000_0000);
        end

        // Absolute redirect mid-stream, then hold the consumer for 10 cycles.
        popped_a.delete();
        snap = accepts_a;
        applyStimulus(1'b1, 1'b0, 32'h2000, 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("redir_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        checkOutput("redir_req_valid", {31'b0, bus_a.imem_req_valid}, 32'd1);
        checkOutput("redir_req_addr", bus_a.imem_req_addr, 32'h2000);
        repeat (9) nextCycle();
        @(negedge clk);
        checkOutput("hold_out_valid", {31'b0, bus_a.out_valid}, 32'd1);
        checkOutput("hold_out_pc", bus_a.out_pc, 32'h2000);
        checkOutput("hold_req_valid", {31'b0, bus_a.imem_req_valid}, 32'd0);
        nextCycle();
        checkOutput("hold_accepts", 32'(accepts_a - snap), 32'(DEPTH));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        repeat (5) nextCycle();
        checkOutput("resume_pops", popped_a.size(), 32'd5);
        if (popped_a.size() >= 3)
            for (int i = 0; i < 3; i++) checkOutput("resume_pc", popped_a[i], 32'h2000 + 32'(4 * i));

        // Relative redirects: negative offset, then a misaligned positive one.
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        waitValid("wait_head_40");
        checkOutput("abs_head_pc", bus_a.out_pc, 32'h40);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        waitValid("wait_head_30");
        checkOutput("rel_neg_pc", bus_a.out_pc, 32'h30);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        waitValid("wait_head_40b");
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h6, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("mis_pulse", {31'b0, bus_a.misalign}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("mis_clear", {31'b0, bus_a.misalign}, 32'd0);
        nextCycle();
        waitValid("wait_head_44");
        checkOutput("mis_target_pc", bus_a.out_pc, 32'h44);

        // Random stalls, then reset while the buffer holds work.
        nextCycle();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (4) nextCycle();
        @(negedge clk);
        checkOutput("pre_rst_out_valid", {31'b0, bus_a.out_valid}, 32'd1);
        nextCycle();
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        checkOutput("midrst_misalign", {31'b0, bus_a.misalign}, 32'd0);
        checkOutput("midrst_req_addr", bus_a.imem_req_addr, 32'h100);
        checkOutput("midrst_b_out_valid", {31'b0, bus_b.out_valid}, 32'd0);
        repeat (2) nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("restart_req_addr", bus_a.imem_req_addr, 32'h100);
        nextCycle();
        waitValid("wait_restart");
        checkOutput("restart_pc", bus_a.out_pc, 32'h100);
        repeat (3) nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
